// File: rtl/aud_player.sv
// Purpose: SRAM-to-DAC playback engine; fetches one 16-bit sample per LRC frame and serializes it LSB first.
// Latency: 3-cycle fetch in the LRC-low half, 16 bit-times in the LRC-high half, o_done one edge after bit 15.
// Backpressure: none; paced by codec BCLK/LRC (each LRC half >= 24 BCLK cycles), SRAM answers one cycle after address.
module aud_player #(
    parameter int ADDR_W = 20,
    parameter int SPD_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow,
    input  logic              i_interp,
    input  logic [SPD_W-1:0]  i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [15:0]       i_sram_data,
    output logic              o_dacdat,
    output logic              o_playing,
    output logic              o_done
);

    localparam int IW = 20;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_WAIT_LOW, S_FETCH, S_WAIT_HIGH, S_SEND, S_PAUSE
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [SPD_W:0]    r_n, w_n_nxt, r_k, w_k_nxt;
    logic              r_fast, w_fast_nxt, r_slow, w_slow_nxt, r_interp, w_interp_nxt;
    logic [1:0]        r_fcnt, w_fcnt_nxt;
    logic [4:0]        r_bit, w_bit_nxt;
    logic [15:0]       r_s0, w_s0_nxt, r_s1, w_s1_nxt, r_word, w_word_nxt;
    logic              r_dacdat, w_dacdat_nxt, r_done, w_done_nxt, r_pend, w_pend_nxt;

    logic [ADDR_W:0]   w_addr_ext, w_end_ext, w_adv_addr;
    logic [ADDR_W-1:0] w_addr_p1;
    logic [SPD_W:0]    w_n_req, w_k_inc, w_adv_k, w_n_minus_k;
    logic              w_mode_fast, w_mode_slow, w_mode_interp;
    logic signed [IW-1:0] w_s0x, w_s1x, w_wa, w_wb, w_nx, w_num;
    logic [15:0]       w_interp;

    // Effective mode comes from the copy latched at fetch; fast and slow together mean normal speed
    assign w_mode_fast   = r_fast & ~r_slow;
    assign w_mode_slow   = r_slow & ~r_fast;
    assign w_mode_interp = w_mode_slow & r_interp;

    // One extra bit so an address step past the end never wraps back into range
    assign w_addr_ext = {1'b0, r_addr};
    assign w_end_ext  = {1'b0, i_end_addr};
    assign w_n_req    = {1'b0, i_speed} + (SPD_W+1)'(1);
    assign w_k_inc    = r_k + (SPD_W+1)'(1);

    // Interpolation partner: next sample, or the same one when sitting on the last address
    assign w_addr_p1 = (w_addr_ext < w_end_ext) ? r_addr + ADDR_W'(1) : r_addr;

    // Second read of an interpolating fetch holds the partner address for two cycles
    assign o_sram_addr = (r_state == S_FETCH && r_fcnt != 2'd0 && w_mode_interp) ? w_addr_p1 : r_addr;

    // (s0*(N-k) + s1*k) / N in 20-bit signed arithmetic; signed division truncates toward zero
    assign w_n_minus_k = r_n - r_k;
    assign w_s0x    = {{(IW-16){r_s0[15]}}, r_s0};
    assign w_s1x    = {{(IW-16){r_s1[15]}}, r_s1};
    assign w_wa     = {{(IW-SPD_W-1){1'b0}}, w_n_minus_k};
    assign w_wb     = {{(IW-SPD_W-1){1'b0}}, r_k};
    assign w_nx     = {{(IW-SPD_W-1){1'b0}}, r_n};
    assign w_num    = w_s0x * w_wa + w_s1x * w_wb;
    assign w_interp = 16'(w_num / w_nx);

    // Position after the current word: skip N in fast, step the phase in slow, else +1
    always_comb begin
        w_adv_addr = w_addr_ext + (ADDR_W+1)'(1);
        w_adv_k    = '0;
        if (w_mode_fast) begin
            w_adv_addr = w_addr_ext + (ADDR_W+1)'(r_n);
        end else if (w_mode_slow) begin
            if (w_k_inc == r_n) begin
                w_adv_addr = w_addr_ext + (ADDR_W+1)'(1);
            end else begin
                w_adv_addr = w_addr_ext;
                w_adv_k    = w_k_inc;
            end
        end
    end

    // Next-state and datapath decisions; stop beats pause beats start
    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_addr;
        w_n_nxt      = r_n;
        w_k_nxt      = r_k;
        w_fast_nxt   = r_fast;
        w_slow_nxt   = r_slow;
        w_interp_nxt = r_interp;
        w_fcnt_nxt   = r_fcnt;
        w_bit_nxt    = r_bit;
        w_s0_nxt     = r_s0;
        w_s1_nxt     = r_s1;
        w_word_nxt   = r_word;
        w_dacdat_nxt = r_dacdat;
        w_done_nxt   = 1'b0;
        w_pend_nxt   = r_pend;
        if (i_stop) begin
            w_state_nxt  = S_IDLE;
            w_addr_nxt   = '0;
            w_k_nxt      = '0;
            w_dacdat_nxt = 1'b0;
            w_pend_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_addr_nxt   = '0;
                    w_k_nxt      = '0;
                    w_dacdat_nxt = 1'b0;
                    if (i_start && !i_pause) w_state_nxt = S_SYNC;
                end
                S_SYNC: begin
                    if (i_pause)    w_state_nxt = S_PAUSE;
                    else if (i_lrc) w_state_nxt = S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (i_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (!i_lrc) begin
                        w_state_nxt  = S_FETCH;
                        w_fcnt_nxt   = 2'd0;
                        w_fast_nxt   = i_fast;
                        w_slow_nxt   = i_slow;
                        w_interp_nxt = i_interp;
                        w_n_nxt      = w_n_req;
                        if (w_n_req != r_n) w_k_nxt = '0;
                    end
                end
                S_FETCH: begin
                    if (i_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else begin
                        w_fcnt_nxt = r_fcnt + 2'd1;
                        case (r_fcnt)
                            2'd0:    w_s0_nxt = i_sram_data;
                            2'd1:    w_s1_nxt = i_sram_data;
                            default: begin
                                w_word_nxt  = w_mode_interp ? w_interp : r_s0;
                                w_state_nxt = S_WAIT_HIGH;
                            end
                        endcase
                    end
                end
                S_WAIT_HIGH: begin
                    if (i_pause) begin
                        w_state_nxt = S_PAUSE;
                    end else if (i_lrc) begin
                        w_state_nxt  = S_SEND;
                        w_dacdat_nxt = r_word[0];
                        w_bit_nxt    = 5'd1;
                    end
                end
                S_SEND: begin
                    if (i_pause) w_pend_nxt = 1'b1;
                    if (r_bit != 5'd16) begin
                        w_dacdat_nxt = r_word[r_bit[3:0]];
                        w_bit_nxt    = r_bit + 5'd1;
                    end else begin
                        w_dacdat_nxt = 1'b0;
                        w_pend_nxt   = 1'b0;
                        if (w_adv_addr > w_end_ext) begin
                            w_done_nxt  = 1'b1;
                            w_addr_nxt  = '0;
                            w_k_nxt     = '0;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_addr_nxt  = w_adv_addr[ADDR_W-1:0];
                            w_k_nxt     = w_adv_k;
                            w_state_nxt = (r_pend || i_pause) ? S_PAUSE : S_WAIT_LOW;
                        end
                    end
                end
                S_PAUSE: begin
                    w_dacdat_nxt = 1'b0;
                    if (i_start && !i_pause) w_state_nxt = S_SYNC;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // All state moves on the BCLK falling edge so DACDAT is stable for the DAC's rising-edge sample
    always_ff @(negedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_n      <= (SPD_W+1)'(1);
            r_k      <= '0;
            r_fast   <= 1'b0;
            r_slow   <= 1'b0;
            r_interp <= 1'b0;
            r_fcnt   <= 2'd0;
            r_bit    <= 5'd0;
            r_s0     <= 16'd0;
            r_s1     <= 16'd0;
            r_word   <= 16'd0;
            r_dacdat <= 1'b0;
            r_done   <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_addr   <= w_addr_nxt;
            r_n      <= w_n_nxt;
            r_k      <= w_k_nxt;
            r_fast   <= w_fast_nxt;
            r_slow   <= w_slow_nxt;
            r_interp <= w_interp_nxt;
            r_fcnt   <= w_fcnt_nxt;
            r_bit    <= w_bit_nxt;
            r_s0     <= w_s0_nxt;
            r_s1     <= w_s1_nxt;
            r_word   <= w_word_nxt;
            r_dacdat <= w_dacdat_nxt;
            r_done   <= w_done_nxt;
            r_pend   <= w_pend_nxt;
        end
    end

    assign o_dacdat  = r_dacdat;
    assign o_done    = r_done;
    assign o_playing = (r_state == S_WAIT_LOW) || (r_state == S_FETCH) ||
                       (r_state == S_WAIT_HIGH) || (r_state == S_SEND);

endmodule
